// File: rtl/hd_fifo_pkg.sv
// Shared definitions for the hd_fifo handshake buffer.
// Holds the default payload width and a log2 helper for derived widths.
package hd_fifo_pkg;

    localparam int HD_DATA_WIDTH = 16;

    // Ceiling log2, kept at least 1 so derived vectors never collapse to zero width
    function automatic int hd_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hd_fifo_ram.sv
// DEPTH x DATA_WIDTH register array for hd_fifo.
// One synchronous write port and one asynchronous read port.
module hd_fifo_ram
    import hd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = HD_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int AW         = hd_clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Payload storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/hd_fifo.sv
// Valid/ready handshake FIFO with occupancy output and synchronous flush.
// Handshake outputs are decoded from registered count only, so there is no input-to-output path.
module hd_fifo
    import hd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = HD_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int AW        = hd_clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      count
);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign s_ready = !w_full;
    assign m_valid = !w_empty;
    assign count   = r_count;

    assign w_push  = s_valid && s_ready;
    assign w_pop   = m_valid && m_ready;

    hd_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push && !flush),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Stale array contents must never leak out while the buffer is empty
    assign m_data = w_empty ? '0 : w_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
